seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display. It shares the single hex-to-segment decoder (inputs D3..D0, LE, point) across four common-anode digits. It rotates through the digits at a programmable rate, inserts a dead-time blank at the start of every digit slot to suppress ghosting, and drives the active-low anode lines. Display data is double-buffered and committed only at frame boundaries, so the display never shows a mix of old and new digits.

## Interface

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot. Must be ≥ 2.
- BLANK_CYC, 16: leading cycles of each slot with all anodes off. Must be < SCAN_DIV; 0 disables blanking.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures data_in/dp_in/digit_en into the shadow registers.
- data_in  in  16  hex digits; [15:12]=digit 3 … [3:0]=digit 0.
- dp_in  in  4  decimal point per digit, active-high; bit n = digit n.
- digit_en  in  4  per-digit enable; 1 = digit shown.
- hex  out  4  nibble for the decoder: hex[3]→D3 … hex[0]→D0.
- le  out  1  decoder LE; 1 = decoder outputs blanked.
- point  out  1  decoder point input, active-high.
- an  out  4  anode select, active-low; an[n] = digit n.
- pending  out  1  shadow holds data not yet committed.
- frame_tick  out  1  one-cycle pulse on each frame commit point.

## Operation

- Registers:
  - cnt: 0..SCAN_DIV-1, slot prescaler.
  - idx: 2-bit digit index.
  - Active set: act_data[15:0], act_dp[3:0], act_en[3:0].
  - Shadow set: sh_data, sh_dp, sh_en.
  - pending.
- Counting:
  - cnt increments every cycle.
  - When cnt==SCAN_DIV-1, cnt←0 and idx←idx+1 (mod 4, so 3 wraps to 0).
  - The digit order is 0,1,2,3,0,…
- Commit point:
  - The commit point is the cycle where idx==3 and cnt==SCAN_DIV-1.
  - On the next edge, if pending==1: active←shadow and pending←0.
  - On that same edge, frame_tick←1 for exactly one cycle, whether or not a commit occurs.
- load:
  - load=1 writes the shadow set on the next edge and sets pending←1.
  - Load during pending: the shadow is overwritten and pending stays 1. Only the last load before the commit is displayed.
  - Load in the commit-point cycle: data_in/dp_in/digit_en go directly into the active set, the shadow is also written, and pending←0.
- Blank condition: blank = (cnt < BLANK_CYC).
- Output decode for the current cnt/idx:
  - If blank or act_en[idx]==0: an=4'b1111, le=1, point=0.
  - Otherwise: an = ~(4'b0001<<idx), le=0, point=act_dp[idx].
  - hex = act_data[4*idx+3 : 4*idx] at all times, including during blank.
- Register placement:
  - All outputs are flops loaded from next-state values, so they are cycle-aligned with cnt/idx. They carry no combinational glitches.
  - At most one an bit is ever 0.
- Reset values (immediate, asynchronous):
  - Internal: cnt=0, idx=0, all active and shadow registers 0, pending=0.
  - Outputs: an=4'b1111, le=1, point=0, hex=0, frame_tick=0.
- Reset mid-operation: all state returns immediately to the reset values. Pending data is discarded.

## Timing

- The first cycle after rst_n rises has cnt=0, idx=0.
- Slot length: SCAN_DIV cycles. Frame length: 4·SCAN_DIV cycles.
- The first frame_tick occurs at cycle 4·SCAN_DIV after reset release.
- Load-to-display latency: from 1 cycle (load in the commit-point cycle) up to 4·SCAN_DIV cycles.
- The new set first appears in the digit-0 slot, in the cycle frame_tick=1 (blanked if BLANK_CYC>0).
- Each slot: BLANK_CYC cycles with the digit off, then SCAN_DIV-BLANK_CYC cycles with the digit lit (if enabled).
- pending falls in the same cycle that frame_tick rises.

## Test plan

All scenarios use SCAN_DIV=8, BLANK_CYC=2.

1. Reset check.
   - Stimulus: hold rst_n=0, then release.
   - Response: during reset, an=1111, le=1, hex=0, frame_tick=0. After release, frame_tick pulses at cycles 32, 64, … and every output cycle has at most one an bit at 0.
2. Basic scan.
   - Stimulus: load data_in=16'h1A2F, dp_in=4'b0100, digit_en=4'hF, then wait for the commit.
   - Response, per slot: cycles 0–1 have an=1111 and le=1; cycles 2–7 have digit 0 an=1110, hex=F; digit 1 an=1101, hex=2; digit 2 an=1011, hex=A, point=1; digit 3 an=0111, hex=1.
   - point=0 everywhere except digit 2.
3. Double buffering.
   - Stimulus: load 16'h1111, then at cycle 10 of the same frame load 16'h2222.
   - Response: only 2222 is displayed after the next frame_tick. pending stays 1 until frame_tick, then 0.
4. Load in the commit-point cycle.
   - Stimulus: assert load exactly when idx=3 and cnt=7.
   - Response: the next cycle shows frame_tick=1, pending=0, and the new hex for digit 0.
5. Digit disable.
   - Stimulus: digit_en=4'b1010.
   - Response: in slots 0 and 2, an=1111, le=1 and point=0 for all 8 cycles. Slots 1 and 3 behave as normal.
6. Reset mid-frame.
   - Stimulus: assert rst_n=0 during slot 2 with pending=1.
   - Response: the reset values apply immediately. After release, the display stays dark (act_en=0) and pending=0.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: load/data bus and display drive lines of the seven-segment scan controller.
interface seg7_scan_ctrl_if;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic [3:0]  hex;
   logic        le;
   logic        point;
   logic [3:0]  an;
   logic        pending;
   logic        frame_tick;
   modport master (output load, data_in, dp_in, digit_en,
                   input  hex, le, point, an, pending, frame_tick);
   modport slave  (input  load, data_in, dp_in, digit_en,
                   output hex, le, point, an, pending, frame_tick);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit common-anode scan controller with per-slot dead-time blanking
// and double-buffered display data committed at frame boundaries.
module seg7_scan_ctrl #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input logic clk,
   input logic rst_n,
   seg7_scan_ctrl_if.slave bus
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    idx, idx_n;
   logic [15:0]   act_data, act_data_n, sh_data;
   logic [3:0]    act_dp, act_dp_n, act_en, act_en_n, sh_dp, sh_en;
   logic          pending, pending_n, commit, off;
   assign bus.pending = pending;
   // Outputs are decoded from next-state values so they register in step with cnt/idx.
   always_comb begin
      commit     = idx == 2'd3 && cnt == LAST;
      cnt_n      = cnt == LAST ? '0 : cnt + 1'b1;
      idx_n      = cnt == LAST ? idx + 2'd1 : idx;
      act_data_n = !commit ? act_data : bus.load ? bus.data_in  : pending ? sh_data : act_data;
      act_dp_n   = !commit ? act_dp   : bus.load ? bus.dp_in    : pending ? sh_dp   : act_dp;
      act_en_n   = !commit ? act_en   : bus.load ? bus.digit_en : pending ? sh_en   : act_en;
      pending_n  = bus.load ? !commit : commit ? 1'b0 : pending;
      off        = cnt_n < BLANK || !act_en_n[idx_n];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= '0;
         idx            <= '0;
         act_data       <= '0;
         act_dp         <= '0;
         act_en         <= '0;
         sh_data        <= '0;
         sh_dp          <= '0;
         sh_en          <= '0;
         pending        <= 1'b0;
         bus.an         <= 4'hF;
         bus.le         <= 1'b1;
         bus.point      <= 1'b0;
         bus.hex        <= 4'h0;
         bus.frame_tick <= 1'b0;
      end else begin
         cnt            <= cnt_n;
         idx            <= idx_n;
         act_data       <= act_data_n;
         act_dp         <= act_dp_n;
         act_en         <= act_en_n;
         if (bus.load) begin
            sh_data <= bus.data_in;
            sh_dp   <= bus.dp_in;
            sh_en   <= bus.digit_en;
         end
         pending        <= pending_n;
         bus.an         <= off ? 4'hF : ~(4'b0001 << idx_n);
         bus.le         <= off;
         bus.point      <= off ? 1'b0 : act_dp_n[idx_n];
         bus.hex        <= act_data_n[idx_n*4 +: 4];
         bus.frame_tick <= commit;
      end
   end
endmodule
